// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: reads a length-prefixed plaintext and writes the length-prefixed ciphertext image.
// Latency: 1 + 256 (INIT) + 1536 (KSA, 6/byte) + 3 (LEN) + 9*L (PRGA) + 1 (DONE) cycles from accept to rdy.
// Backpressure: none downstream; en is honoured only while rdy=1, and requests made while busy are dropped.
module arc4_encrypt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_wrdata,
  output logic        s_wren,
  input  logic [7:0]  s_rddata,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata,
  output logic [7:0]  ct_addr,
  output logic [7:0]  ct_wrdata,
  output logic        ct_wren
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    KSA  = 3'd2,
    LEN  = 3'd3,
    PRGA = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  step;     // sub-cycle position inside one KSA/LEN/PRGA iteration
  logic [7:0]  i;
  logic [7:0]  j;
  logic [7:0]  si;       // S[i] as read before the swap
  logic [7:0]  sj;       // S[j] as read before the swap
  logic [7:0]  len;
  logic [7:0]  n;        // index of the pt/ct byte being processed
  logic [7:0]  ptb;      // plaintext byte for the current PRGA iteration
  logic [1:0]  km;       // i mod 3, tracked incrementally
  logic [23:0] key_q;
  logic [7:0]  kbyte;
  logic [7:0]  ksa_j;
  logic [7:0]  prga_j;
  logic [7:0]  i_inc;

  // Key byte selection and the wrapping index arithmetic used by the datapath
  always_comb begin
    case (km)
      2'd0:    kbyte = key_q[23:16];
      2'd1:    kbyte = key_q[15:8];
      default: kbyte = key_q[7:0];
    endcase
    ksa_j  = j + s_rddata + kbyte;
    prga_j = j + s_rddata;
    i_inc  = i + 8'd1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode: phase boundaries fall on the last sub-step of the last iteration
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en) state_nxt = INIT;
      INIT: if (i == 8'hFF) state_nxt = KSA;
      KSA:  if (step == 4'd5 && i == 8'hFF) state_nxt = LEN;
      LEN:  if (step == 4'd2) state_nxt = (pt_rddata == 8'd0) ? DONE : PRGA;
      PRGA: if (step == 4'd8 && n == len) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: ready only while idle
  always_comb begin
    rdy = (state == IDLE);
  end

  // Datapath and registered memory ports; read data arrives two edges after the address is chosen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step      <= 4'd0;
      i         <= 8'd0;
      j         <= 8'd0;
      si        <= 8'd0;
      sj        <= 8'd0;
      len       <= 8'd0;
      n         <= 8'd0;
      ptb       <= 8'd0;
      km        <= 2'd0;
      key_q     <= 24'd0;
      s_addr    <= 8'd0;
      s_wrdata  <= 8'd0;
      s_wren    <= 1'b0;
      pt_addr   <= 8'd0;
      ct_addr   <= 8'd0;
      ct_wrdata <= 8'd0;
      ct_wren   <= 1'b0;
    end else begin
      s_wren  <= 1'b0;
      ct_wren <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            key_q   <= key;
            i       <= 8'd0;
            step    <= 4'd0;
            pt_addr <= 8'd0;
          end
        end
        INIT: begin
          s_addr   <= i;
          s_wrdata <= i;
          s_wren   <= 1'b1;
          i        <= i_inc;
          if (i == 8'hFF) begin
            j  <= 8'd0;
            km <= 2'd0;
          end
        end
        KSA: begin
          case (step)
            4'd0: begin
              s_addr <= i;
              step   <= 4'd1;
            end
            4'd2: begin
              si     <= s_rddata;
              j      <= ksa_j;
              s_addr <= ksa_j;
              step   <= 4'd3;
            end
            4'd4: begin
              sj       <= s_rddata;
              s_addr   <= i;
              s_wrdata <= s_rddata;
              s_wren   <= 1'b1;
              step     <= 4'd5;
            end
            4'd5: begin
              s_addr   <= j;
              s_wrdata <= si;
              s_wren   <= 1'b1;
              i        <= i_inc;
              km       <= (km == 2'd2) ? 2'd0 : km + 2'd1;
              step     <= 4'd0;
              if (i == 8'hFF) j <= 8'd0;
            end
            default: step <= step + 4'd1;
          endcase
        end
        LEN: begin
          case (step)
            4'd0: begin
              pt_addr <= 8'd0;
              step    <= 4'd1;
            end
            4'd2: begin
              len       <= pt_rddata;
              ct_addr   <= 8'd0;
              ct_wrdata <= pt_rddata;
              ct_wren   <= 1'b1;
              n         <= 8'd1;
              step      <= 4'd0;
            end
            default: step <= step + 4'd1;
          endcase
        end
        PRGA: begin
          case (step)
            4'd0: begin
              i       <= i_inc;
              s_addr  <= i_inc;
              pt_addr <= n;
              step    <= 4'd1;
            end
            4'd2: begin
              si     <= s_rddata;
              j      <= prga_j;
              s_addr <= prga_j;
              ptb    <= pt_rddata;
              step   <= 4'd3;
            end
            4'd4: begin
              sj       <= s_rddata;
              s_addr   <= i;
              s_wrdata <= s_rddata;
              s_wren   <= 1'b1;
              step     <= 4'd5;
            end
            4'd5: begin
              s_addr   <= j;
              s_wrdata <= si;
              s_wren   <= 1'b1;
              step     <= 4'd6;
            end
            4'd6: begin
              // post-swap S[i]+S[j] equals sj+si, so the pre-swap copies suffice
              s_addr <= si + sj;
              step   <= 4'd7;
            end
            4'd8: begin
              ct_addr   <= n;
              ct_wrdata <= s_rddata ^ ptb;
              ct_wren   <= 1'b1;
              n         <= n + 8'd1;
              step      <= 4'd0;
            end
            default: step <= step + 4'd1;
          endcase
        end
        DONE: begin
          step <= 4'd0;
        end
        default: step <= 4'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Directed bench for arc4_encrypt with behavioural S/PT/CT memories and an ARC4 reference.
// Latency: each run is bounded by a cycle budget; an expired budget shows up as a latency check failure.
// Backpressure: stimulus only raises en while rdy=1, except the deliberate held-en scenario.
module tb_arc4_encrypt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        rdy;
  logic [23:0] key = 24'd0;
  logic [7:0]  s_addr, s_wrdata, s_rddata;
  logic        s_wren;
  logic [7:0]  pt_addr, pt_rddata;
  logic [7:0]  ct_addr, ct_wrdata;
  logic        ct_wren;

  arc4_encrypt dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren), .s_rddata(s_rddata),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren)
  );

  always #5 clk = ~clk;

  logic [7:0] s_mem [256];
  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];
  logic [7:0] exp_ct [256];
  logic [7:0] saved [256];
  logic [7:0] std_pt [10];
  logic [7:0] std_ct [10];
  logic [7:0] s_q = 8'd0;
  logic [7:0] pt_q = 8'd0;
  logic       ct_clr = 1'b0;
  int         wr_count = 0;
  int         order_err = 0;
  int         pt_over = 0;
  logic [7:0] last_ct = 8'd0;
  int         checks = 0;
  int         errors = 0;

  assign s_rddata  = s_q;
  assign pt_rddata = pt_q;

  // Synchronous single-port memories: one-cycle read latency, write at the wren edge
  always @(posedge clk) begin
    if (s_wren) s_mem[s_addr] <= s_wrdata;
    s_q  <= s_mem[s_addr];
    pt_q <= pt_mem[pt_addr];
  end

  // CT memory plus write-order and plaintext-overread monitors
  always @(posedge clk) begin
    if (ct_clr) begin
      for (int a = 0; a < 256; a++) ct_mem[a] <= 8'hEE;
    end else if (ct_wren) begin
      ct_mem[ct_addr] <= ct_wrdata;
      wr_count <= wr_count + 1;
      if (ct_addr != 8'd0 && ct_addr != last_ct + 8'd1) order_err <= order_err + 1;
      last_ct <= ct_addr;
    end
    if (!rdy && pt_addr > pt_mem[0]) pt_over <= pt_over + 1;
  end

  task automatic clear_ct();
    ct_clr = 1'b1;
    @(posedge clk);
    #1 ct_clr = 1'b0;
  endtask

  task automatic load_std();
    for (int a = 0; a < 256; a++) pt_mem[a] = 8'h00;
    for (int a = 0; a < 10; a++) pt_mem[a] = std_pt[a];
  endtask

  // Issues one run (caller guarantees rdy=1) and returns edges from accept to rdy
  task automatic do_run(input logic [23:0] k, output int lat);
    key = k;
    en  = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    lat = 0;
    while (lat < 5000) begin
      @(posedge clk);
      lat++;
      #1;
      if (rdy) break;
    end
  endtask

  // Reference ARC4 encryption of the current pt_mem image into exp_ct
  task automatic model_encrypt(input logic [23:0] k);
    logic [7:0] S [256];
    logic [7:0] kb [3];
    logic [7:0] ii, jj, t, L;
    kb[0] = k[23:16];
    kb[1] = k[15:8];
    kb[2] = k[7:0];
    for (int a = 0; a < 256; a++) S[a] = a[7:0];
    jj = 8'd0;
    for (int a = 0; a < 256; a++) begin
      jj = jj + S[a] + kb[a % 3];
      t = S[a]; S[a] = S[jj]; S[jj] = t;
    end
    L = pt_mem[0];
    exp_ct[0] = L;
    ii = 8'd0;
    jj = 8'd0;
    for (int m = 1; m <= int'(L); m++) begin
      ii = ii + 8'd1;
      jj = jj + S[ii];
      t = S[ii]; S[ii] = S[jj]; S[jj] = t;
      t = S[ii] + S[jj];
      exp_ct[m] = S[t] ^ pt_mem[m];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got=%b want=1", rdy); end
    checks++;
    if (s_wren !== 1'b0 || ct_wren !== 1'b0) begin
      errors++; $display("FAIL reset_wren got s=%b ct=%b want 0 0", s_wren, ct_wren);
    end
    checks++;
    if ({s_addr, s_wrdata, pt_addr, ct_addr, ct_wrdata} !== 40'd0) begin
      errors++; $display("FAIL reset_addr_data got=%h want=0", {s_addr, s_wrdata, pt_addr, ct_addr, ct_wrdata});
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_standard();
    int lat, w0, o0;
    load_std();
    clear_ct();
    w0 = wr_count; o0 = order_err;
    do_run(24'h4B6579, lat);
    checks++;
    if (lat > 1881) begin errors++; $display("FAIL std_latency got=%0d want<=1881", lat); end
    checks++;
    if (wr_count - w0 != 10) begin errors++; $display("FAIL std_wr_count got=%0d want=10", wr_count - w0); end
    checks++;
    if (order_err != o0) begin errors++; $display("FAIL std_order got=%0d want=%0d", order_err, o0); end
    for (int a = 0; a < 10; a++) begin
      checks++;
      if (ct_mem[a] !== std_ct[a]) begin
        errors++; $display("FAIL std_ct[%0d] got=%h want=%h", a, ct_mem[a], std_ct[a]);
      end
    end
  endtask

  task automatic test_empty();
    int lat, w0, p0;
    for (int a = 0; a < 256; a++) pt_mem[a] = 8'h55;
    pt_mem[0] = 8'h00;
    clear_ct();
    w0 = wr_count; p0 = pt_over;
    do_run(24'hABCDEF, lat);
    checks++;
    if (lat > 1803) begin errors++; $display("FAIL empty_latency got=%0d want<=1803", lat); end
    checks++;
    if (wr_count - w0 != 1) begin errors++; $display("FAIL empty_wr_count got=%0d want=1", wr_count - w0); end
    checks++;
    if (ct_mem[0] !== 8'h00) begin errors++; $display("FAIL empty_ct0 got=%h want=00", ct_mem[0]); end
    checks++;
    if (ct_mem[1] !== 8'hEE) begin errors++; $display("FAIL empty_ct1_untouched got=%h want=EE", ct_mem[1]); end
    checks++;
    if (pt_over != p0) begin errors++; $display("FAIL empty_pt_overread got=%0d want=0", pt_over - p0); end
  endtask

  task automatic test_roundtrip();
    int lat, w0, p0;
    logic [7:0] orig [256];
    pt_mem[0] = 8'd255;
    for (int a = 1; a < 256; a++) pt_mem[a] = 8'($urandom_range(0, 255));
    for (int a = 0; a < 256; a++) orig[a] = pt_mem[a];
    model_encrypt(24'h000018);
    clear_ct();
    w0 = wr_count; p0 = pt_over;
    do_run(24'h000018, lat);
    checks++;
    if (lat > 1800 + 9 * 255) begin errors++; $display("FAIL rt_latency got=%0d want<=%0d", lat, 1800 + 9 * 255); end
    checks++;
    if (wr_count - w0 != 256) begin errors++; $display("FAIL rt_wr_count got=%0d want=256", wr_count - w0); end
    checks++;
    if (pt_over != p0) begin errors++; $display("FAIL rt_pt_overread got=%0d want=0", pt_over - p0); end
    for (int a = 0; a < 256; a++) begin
      checks++;
      if (ct_mem[a] !== exp_ct[a]) begin
        errors++; $display("FAIL rt_enc[%0d] got=%h want=%h", a, ct_mem[a], exp_ct[a]);
      end
    end
    for (int a = 0; a < 256; a++) pt_mem[a] = ct_mem[a];
    clear_ct();
    do_run(24'h000018, lat);
    for (int a = 0; a < 256; a++) begin
      checks++;
      if (ct_mem[a] !== orig[a]) begin
        errors++; $display("FAIL rt_dec[%0d] got=%h want=%h", a, ct_mem[a], orig[a]);
      end
    end
  endtask

  task automatic test_en_held();
    int lat, w0;
    load_std();
    clear_ct();
    w0 = wr_count;
    key = 24'h4B6579;
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (400) @(posedge clk);
    #1 en = 1'b1;
    repeat (50) @(posedge clk);
    #1 en = 1'b0;
    lat = 451;
    while (lat < 5000) begin
      @(posedge clk);
      lat++;
      #1;
      if (rdy) break;
    end
    checks++;
    if (lat > 1881) begin errors++; $display("FAIL held_latency got=%0d want<=1881", lat); end
    repeat (60) @(posedge clk);
    #1;
    checks++;
    if (wr_count - w0 != 10) begin errors++; $display("FAIL held_wr_count got=%0d want=10", wr_count - w0); end
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL held_idle_rdy got=%b want=1", rdy); end
    for (int a = 0; a < 10; a++) begin
      checks++;
      if (ct_mem[a] !== std_ct[a]) begin
        errors++; $display("FAIL held_ct[%0d] got=%h want=%h", a, ct_mem[a], std_ct[a]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    load_std();
    clear_ct();
    key = 24'h4B6579;
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (1830) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL mid_busy_before_reset got=%b want=0", rdy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rdy !== 1'b1 || s_wren !== 1'b0 || ct_wren !== 1'b0) begin
      errors++; $display("FAIL mid_async_ctrl got rdy=%b s_wren=%b ct_wren=%b want 1 0 0", rdy, s_wren, ct_wren);
    end
    checks++;
    if ({s_addr, s_wrdata, pt_addr, ct_addr, ct_wrdata} !== 40'd0) begin
      errors++; $display("FAIL mid_async_addr got=%h want=0", {s_addr, s_wrdata, pt_addr, ct_addr, ct_wrdata});
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL mid_rdy_after got=%b want=1", rdy); end
    clear_ct();
    do_run(24'h4B6579, lat);
    for (int a = 0; a < 10; a++) begin
      checks++;
      if (ct_mem[a] !== std_ct[a]) begin
        errors++; $display("FAIL mid_rerun_ct[%0d] got=%h want=%h", a, ct_mem[a], std_ct[a]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, w0;
    load_std();
    clear_ct();
    model_encrypt(24'h000001);
    w0 = wr_count;
    do_run(24'h4B6579, lat1);
    for (int a = 0; a < 256; a++) saved[a] = ct_mem[a];
    do_run(24'h000001, lat2);
    checks++;
    if (lat1 > 1881 || lat2 > 1881) begin
      errors++; $display("FAIL b2b_latency got=%0d,%0d want<=1881", lat1, lat2);
    end
    checks++;
    if (wr_count - w0 != 20) begin errors++; $display("FAIL b2b_wr_count got=%0d want=20", wr_count - w0); end
    for (int a = 0; a < 10; a++) begin
      checks++;
      if (saved[a] !== std_ct[a]) begin
        errors++; $display("FAIL b2b_first_ct[%0d] got=%h want=%h", a, saved[a], std_ct[a]);
      end
      checks++;
      if (ct_mem[a] !== exp_ct[a]) begin
        errors++; $display("FAIL b2b_second_ct[%0d] got=%h want=%h", a, ct_mem[a], exp_ct[a]);
      end
    end
  endtask

  initial begin
    std_pt = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    std_ct = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    for (int a = 0; a < 256; a++) begin
      s_mem[a]  = 8'h00;
      pt_mem[a] = 8'h00;
    end
    test_reset();
    test_standard();
    test_empty();
    test_roundtrip();
    test_en_held();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arc4_encrypt.md
# arc4_encrypt

Encrypts a length-prefixed plaintext message with ARC4 under a 24-bit key and writes the length-prefixed ciphertext into the CT memory read by the decrypt and crack datapath. It is the producer end of the CT memory format: byte 0 holds the length L (0–255), and bytes 1..L hold the data. It drives its own 256×8 S memory and a read-only plaintext memory, and uses the same en/rdy start handshake as the other ARC4 blocks. Benches use it to generate CT images in-circuit rather than loading them from .memh files.

## Interface
Parameters:
- none; key length fixed at 3 bytes.

Ports:
- `clk` in 1 — single clock, all logic rising-edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `en` in 1 — start request; sampled only while `rdy`=1.
- `rdy` out 1 — 1 = idle and able to accept `en`.
- `key` in 24 — key bytes: k[0]=`key[23:16]`, k[1]=`key[15:8]`, k[2]=`key[7:0]`; captured on accepted `en`.
- `s_addr` out 8, `s_wrdata` out 8, `s_wren` out 1, `s_rddata` in 8 — S memory port.
- `pt_addr` out 8, `pt_rddata` in 8 — plaintext memory read port.
- `ct_addr` out 8, `ct_wrdata` out 8, `ct_wren` out 1 — ciphertext memory write port.

All memories are single-port synchronous RAMs. Read data is valid on the cycle after the address is presented, and a write completes at the clock edge where `wren`=1.

## Operation
- Handshake: `en`=1 while `rdy`=1 starts a run at that edge, and `rdy` drops on the next cycle. `en` while busy is ignored (no queueing). `rdy` rises exactly once per run, after the final CT write has been committed.
- States: IDLE → INIT → KSA → LEN → PRGA → DONE → IDLE.
- INIT: for i = 0..255, S[i] = i, one write per cycle, ascending.
- KSA: j = 0; for i = 0..255:
  - j = (j + S[i] + k[i mod 3]) mod 256;
  - swap S[i] and S[j]. Read both values before either write. When i = j, S is left unchanged.
- LEN: read L = pt[0] and write ct[0] = L.
- PRGA: i = j = 0; for n = 1..L:
  - i = (i+1) mod 256;
  - j = (j + S[i]) mod 256;
  - swap S[i] and S[j];
  - pad = S[(S[i] + S[j]) mod 256], using the post-swap values;
  - ct[n] = pad XOR pt[n].
- Arithmetic: all 8-bit, wrapping mod 256, with no carry retained.
- L = 0: ct[0] = 0 is written, no PRGA iterations run, and the block goes to DONE.
- L = 255: the last write goes to ct_addr 255, and the addresses do not wrap.
- `pt_addr` never exceeds L. The block never reads pt beyond the declared length.
- Reset mid-run: all state is discarded immediately. After release the block is in IDLE with `rdy`=1, and S and CT contents are undefined until the next complete run.

## Timing
- Reset values: `rdy`=1, `s_wren`=`ct_wren`=0, and all address and wrdata outputs = 0.
- `s_wren` and `ct_wren` are each 1-cycle pulses. They are driven from registers and are never combinational from inputs.
- `ct_wren` pulses exactly L+1 times per run, at `ct_addr` = 0, 1, …, L in strictly ascending order.
- Phase latencies:
  - INIT: exactly 256 cycles.
  - KSA: ≤ 6 cycles per i (≤ 1536 total).
  - LEN: ≤ 3 cycles.
  - PRGA: ≤ 9 cycles per byte.
- Total run latency, from the accepting `en` edge to `rdy`=1, is ≤ 1800 + 9·L cycles.
- A new `en` is accepted in the same cycle that `rdy` is first high, so runs can be issued back to back.
- `key` and the pt contents must stay stable from the accepting edge until `rdy` returns.

## Test plan
- Standard vector: key = 24'h4B6579 ("Key"), pt = 09 50 6C 61 69 6E 74 65 78 74 ("Plaintext") → ct = 09 BB F3 16 E8 D9 40 AF 0A D3. Check exactly 10 `ct_wren` pulses and that `rdy` returns within 1881 cycles.
- Empty message: pt[0] = 00, any key → a single CT write (addr 0, data 00), no pt read above address 0, and `rdy` returns within 1803 cycles.
- Round trip at maximum length: L = 255, random pt, key 24'h00_0018 → feed the CT image back in as pt with the same key. The result must equal the original pt, byte for byte.
- `en` held high for 50 cycles during KSA → exactly one run, the first CT output is unchanged, and there are no extra `ct_wren` pulses.
- Reset mid-run: pulse `rst_n` low for 1 cycle mid-PRGA. All outputs must return to their reset values asynchronously, and `rdy`=1 after release. A fresh run with the standard vector must then produce the correct ct.
- Back to back: assert `en` on the first `rdy` cycle with a new key, 24'h4B6579 → 24'h000001. The second CT image must match a software ARC4 model, and no run may be lost.
